// File: rtl/dp_rr_sched.sv
// dp_rr_sched: round-robin scheduler sharing one W-bit datapath engine
// between NREQ requesters. One operand is in flight at a time; the
// result returns tagged with the requester index.
// Optional feature: define DP_RR_SCHED_TIMEOUT_EN to abort a WAIT that
// lasts TMO cycles and return an error response instead.
module dp_rr_sched #(
    parameter int NREQ = 4,
    parameter int W    = 8,
    parameter int TMO  = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NREQ-1:0]   req,
    input  logic [NREQ*W-1:0] req_data,
    output logic [NREQ-1:0]   gnt,
    output logic              dp_start,
    output logic [W-1:0]      dp_opnd,
    input  logic              dp_done,
    input  logic [W-1:0]      dp_res,
    output logic              rsp_vld,
    output logic [2:0]        rsp_id,
    output logic [W-1:0]      rsp_data,
    output logic              rsp_err,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    state_t         state_q, state_d;
    logic [2:0]     ptr_q, ptr_d;
    logic [2:0]     id_q, id_d;
    logic [W-1:0]   opnd_q, opnd_d;
    logic [W-1:0]   data_q, data_d;

`ifdef DP_RR_SCHED_TIMEOUT_EN
    localparam int CW = $clog2(TMO + 1);
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           err_q, err_d;
`endif

    // Requests and operands widened to 8 lanes so a 3-bit index always fits.
    logic [7:0]     req_pad;
    logic [8*W-1:0] data_pad;
    logic [7:0]     gnt_pad;
    logic [2:0]     win;
    logic           any;
    logic [3:0]     idx;
    logic [3:0]     nxt;

    // Round-robin pick: first set request at or above the pointer, wrapping.
    // Scanning from the far end means the closest-to-pointer hit is written last.
    always_comb begin
        req_pad              = '0;
        req_pad[NREQ-1:0]    = req;
        data_pad             = '0;
        data_pad[NREQ*W-1:0] = req_data;
        win                  = '0;
        any                  = 1'b0;
        idx                  = '0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            idx = {1'b0, ptr_q} + 4'(i);
            if (idx >= 4'(NREQ)) idx = idx - 4'(NREQ);
            if (req_pad[idx[2:0]]) begin
                win = idx[2:0];
                any = 1'b1;
            end
        end
        nxt = {1'b0, win} + 4'd1;
        if (nxt == 4'(NREQ)) nxt = '0;
    end

    // Next-state and Moore/Mealy outputs of the scheduler FSM.
    always_comb begin
        state_d  = state_q;
        ptr_d    = ptr_q;
        id_d     = id_q;
        opnd_d   = opnd_q;
        data_d   = data_q;
        gnt_pad  = '0;
        dp_start = 1'b0;
        rsp_vld  = 1'b0;
`ifdef DP_RR_SCHED_TIMEOUT_EN
        cnt_d    = cnt_q;
        err_d    = err_q;
`endif
        case (state_q)
            IDLE: begin
                // gnt is combinational; suppressed while reset is applied.
                if (any && !rst) begin
                    gnt_pad = 8'd1 << win;
                    id_d    = win;
                    opnd_d  = data_pad[win*W +: W];
                    ptr_d   = nxt[2:0];
                    state_d = ISSUE;
`ifdef DP_RR_SCHED_TIMEOUT_EN
                    err_d   = 1'b0;
`endif
                end
            end
            ISSUE: begin
                dp_start = 1'b1;
                state_d  = WAIT;
`ifdef DP_RR_SCHED_TIMEOUT_EN
                cnt_d    = '0;
`endif
            end
            WAIT: begin
                // A completion in the final counted cycle still wins.
                if (dp_done) begin
                    data_d  = dp_res;
                    state_d = RESP;
`ifdef DP_RR_SCHED_TIMEOUT_EN
                end else if (cnt_q == CW'(TMO - 1)) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = RESP;
                end else begin
                    cnt_d   = cnt_q + 1'b1;
`endif
                end
            end
            RESP: begin
                rsp_vld = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign gnt      = gnt_pad[NREQ-1:0];
    assign busy     = (state_q != IDLE);
    assign dp_opnd  = opnd_q;
    assign rsp_id   = id_q;
    assign rsp_data = data_q;
`ifdef DP_RR_SCHED_TIMEOUT_EN
    assign rsp_err  = rsp_vld & err_q;
`else
    assign rsp_err  = 1'b0;
`endif

    // State and datapath registers; reset abandons any transaction in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            opnd_q  <= '0;
            data_q  <= '0;
`ifdef DP_RR_SCHED_TIMEOUT_EN
            cnt_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            opnd_q  <= opnd_d;
            data_q  <= data_d;
`ifdef DP_RR_SCHED_TIMEOUT_EN
            cnt_q   <= cnt_d;
            err_q   <= err_d;
`endif
        end
    end

endmodule

// File: tb/tb_dp_rr_sched.sv
// Bench for dp_rr_sched: engine model, round-robin reference model and a
// response scoreboard. Build with DP_RR_SCHED_TIMEOUT_EN to add timeout cases.
module tb_dp_rr_sched;

    localparam int NREQ = 4;
    localparam int W    = 8;
    localparam int TMO  = 16;

    logic              clk = 1'b0;
    logic              rst;
    logic [NREQ-1:0]   req;
    logic [NREQ*W-1:0] req_data;
    logic [NREQ-1:0]   gnt;
    logic              dp_start;
    logic [W-1:0]      dp_opnd;
    logic              dp_done;
    logic [W-1:0]      dp_res;
    logic              rsp_vld;
    logic [2:0]        rsp_id;
    logic [W-1:0]      rsp_data;
    logic              rsp_err;
    logic              busy;

    dp_rr_sched #(.NREQ(NREQ), .W(W), .TMO(TMO)) dut (
        .clk(clk), .rst(rst), .req(req), .req_data(req_data), .gnt(gnt),
        .dp_start(dp_start), .dp_opnd(dp_opnd), .dp_done(dp_done), .dp_res(dp_res),
        .rsp_vld(rsp_vld), .rsp_id(rsp_id), .rsp_data(rsp_data), .rsp_err(rsp_err),
        .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [2:0]   id;
        logic [W-1:0] data;
        logic         err;
    } exp_t;

    exp_t            sb_q[$];
    int              gnt_log[$];
    int              n_chk = 0;
    int              n_fail = 0;
    int              ptr_m = 0;
    bit              m_busy = 0;
    bit              prev_gnt = 0;
    bit              prev_done_wait = 0;
    bit              hold = 0;
    bit              eng_en = 1;
    int              eng_lat = 3;
    bit              exp_tmo = 0;
    logic [W-1:0]    exp_opnd = '0;
    logic [NREQ-1:0] clr_pend = '0;
    int              e3[6] = '{0, 1, 2, 3, 0, 1};
    int              e4[3] = '{2, 0, 2};
    int              e5[2] = '{0, 1};

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, act, exp, $time);
        end
    endtask

    // Reference model + scoreboard, sampled mid-cycle.
    int              mk;
    logic [NREQ-1:0] mg;
    bit              b, pg;
    exp_t            e;
    always @(negedge clk) begin
        if (rst) begin
            ptr_m = 0; m_busy = 0; prev_gnt = 0; prev_done_wait = 0;
            sb_q.delete(); gnt_log.delete(); clr_pend = '0;
        end else begin
            b  = m_busy;
            pg = prev_gnt;
            chk("busy", {31'd0, busy}, {31'd0, b});
            chk("start_lat", {31'd0, dp_start}, {31'd0, pg});
            if (prev_done_wait) chk("rsp_lat", {31'd0, rsp_vld}, 32'd1);
            mk = -1;
            mg = '0;
            if (!b)
                for (int i = NREQ - 1; i >= 0; i--)
                    if (req[(ptr_m + i) % NREQ]) mk = (ptr_m + i) % NREQ;
            if (mk >= 0) mg[mk] = 1'b1;
            chk("gnt", 32'(gnt), 32'(mg));
            if (mk >= 0) begin
                e.id   = 3'(mk);
                e.data = exp_tmo ? '0 : ~req_data[mk*W +: W];
                e.err  = exp_tmo;
                sb_q.push_back(e);
                exp_opnd = req_data[mk*W +: W];
                ptr_m    = (mk + 1) % NREQ;
                m_busy   = 1;
                gnt_log.push_back(mk);
                clr_pend[mk] = 1'b1;
            end
            if (dp_start) chk("opnd", 32'(dp_opnd), 32'(exp_opnd));
            if (rsp_vld) begin
                if (sb_q.size() == 0) chk("spurious_rsp", 32'd1, 32'd0);
                else begin
                    e = sb_q.pop_front();
                    chk("rsp_id", 32'(rsp_id), 32'(e.id));
                    chk("rsp_data", 32'(rsp_data), 32'(e.data));
                    chk("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
                end
                m_busy = 0;
            end else begin
                chk("err_idle", {31'd0, rsp_err}, 32'd0);
            end
            prev_done_wait = dp_done && b && !pg && !rsp_vld;
            prev_gnt = (gnt != '0);
        end
    end

    // Requesters drop their request once granted (unless holding).
    initial forever begin
        @(posedge clk);
        #1;
        if (!hold) req = req & ~clr_pend;
        clr_pend = '0;
    end

    // Engine model: result = ~operand, dp_done eng_lat cycles after dp_start.
    logic [W-1:0] eopnd;
    initial begin
        dp_done = 1'b0;
        dp_res  = '0;
        forever begin
            @(negedge clk);
            if (dp_start && eng_en) begin
                eopnd = dp_opnd;
                repeat (eng_lat) @(posedge clk);
                #1;
                chk("opnd_hold", 32'(dp_opnd), 32'(eopnd));
                dp_done = 1'b1;
                dp_res  = ~eopnd;
                @(posedge clk);
                #1;
                dp_done = 1'b0;
            end
        end
    end

    task automatic do_reset();
        @(posedge clk);
        #2 rst = 1'b1; req = '0;
        @(posedge clk);
        #2 rst = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (req == '0 && !busy && sb_q.size() == 0 && !dp_done) return;
        end
        chk({tag, "_idle_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic wait_log(input int n, input string tag);
        for (int i = 0; i < 300; i++) begin
            @(posedge clk);
            #2;
            if (gnt_log.size() >= n) return;
        end
        chk({tag, "_gnt_timeout"}, 32'(gnt_log.size()), 32'(n));
    endtask

`ifdef DP_RR_SCHED_TIMEOUT_EN
    // Grant-to-response distance, in cycles, for one request from requester 0.
    task automatic tmo_run(input string tag, input int exp_dist);
        int n, g, r;
        n = 0; g = -1; r = -1;
        @(posedge clk);
        #2 req_data[7:0] = 8'h3C; req = 4'b0001;
        while (n < 80 && r < 0) begin
            @(negedge clk);
            if (gnt != '0) g = n;
            if (rsp_vld) r = n;
            n++;
        end
        chk(tag, 32'(r - g), 32'(exp_dist));
        wait_idle(tag);
    endtask
`endif

    initial begin
        rst = 1'b1; req = '0; req_data = '0;
        repeat (2) @(posedge clk);
        #2 rst = 1'b0;

        // Reset state and quiet idle
        repeat (10) begin
            @(negedge clk);
            chk("rst_gnt", 32'(gnt), 32'd0);
            chk("rst_busy", {31'd0, busy}, 32'd0);
            chk("rst_start", {31'd0, dp_start}, 32'd0);
            chk("rst_vld", {31'd0, rsp_vld}, 32'd0);
            chk("rst_opnd", 32'(dp_opnd), 32'd0);
            chk("rst_id", 32'(rsp_id), 32'd0);
            chk("rst_data", 32'(rsp_data), 32'd0);
            chk("rst_err", {31'd0, rsp_err}, 32'd0);
        end

        // Single request, engine latency 3
        eng_lat = 3;
        @(posedge clk);
        #2 req_data[7:0] = 8'h5A; req = 4'b0001;
        wait_idle("t2");
        chk("t2_data_held", 32'(rsp_data), 32'hA5);
        chk("t2_id_held", 32'(rsp_id), 32'd0);

        // Round robin with all requests held, latency 1
        do_reset();
        eng_lat = 1; hold = 1;
        req_data = {8'hD4, 8'h1F, 8'h80, 8'h07};
        req = 4'hF;
        wait_log(6, "t3");
        req = '0; hold = 0;
        wait_idle("t3");
        chk("t3_cnt", 32'(gnt_log.size()), 32'd6);
        for (int i = 0; i < 6 && i < gnt_log.size(); i++)
            chk($sformatf("t3_ord%0d", i), 32'(gnt_log[i]), 32'(e3[i]));

        // Pointer skip/wrap; requester 3 raises and drops while busy
        do_reset();
        eng_lat = 4;
        req_data = {8'hC3, 8'h66, 8'h99, 8'h01};
        req = 4'b0100;
        wait_log(1, "t4");
        req = req | 4'b1000;
        repeat (2) @(posedge clk);
        #2 req = req & 4'b0111;
        wait_idle("t4a");
        req = 4'b0101;
        wait_idle("t4b");
        chk("t4_cnt", 32'(gnt_log.size()), 32'd3);
        for (int i = 0; i < 3 && i < gnt_log.size(); i++)
            chk($sformatf("t4_ord%0d", i), 32'(gnt_log[i]), 32'(e4[i]));

        // Reset in WAIT, then a stray dp_done
        eng_en = 0;
        req = 4'b0001;
        wait_log(4, "t5");
        repeat (3) @(posedge clk);
        chk("t5_in_wait", {31'd0, busy}, 32'd1);
        #2 rst = 1'b1; req = '0;
        @(posedge clk);
        #2 rst = 1'b0;
        repeat (2) @(posedge clk);
        #1 dp_done = 1'b1; dp_res = 8'h33;
        @(posedge clk);
        #1 dp_done = 1'b0;
        repeat (6) begin
            @(negedge clk);
            chk("t5_no_vld", {31'd0, rsp_vld}, 32'd0);
            chk("t5_idle", {31'd0, busy}, 32'd0);
        end
        eng_en = 1; eng_lat = 2;
        req = 4'b0011;
        wait_idle("t5");
        chk("t5_cnt", 32'(gnt_log.size()), 32'd2);
        for (int i = 0; i < 2 && i < gnt_log.size(); i++)
            chk($sformatf("t5_ord%0d", i), 32'(gnt_log[i]), 32'(e5[i]));

`ifdef DP_RR_SCHED_TIMEOUT_EN
        // No completion: error response after TMO WAIT cycles
        do_reset();
        eng_en = 0; exp_tmo = 1;
        tmo_run("t6_tmo_dist", TMO + 2);
        // Completion one cycle too late: still a timeout, late strobe ignored
        eng_en = 1; eng_lat = TMO + 1;
        tmo_run("t6_late_dist", TMO + 2);
        // Completion exactly at the limit: normal response
        exp_tmo = 0; eng_lat = TMO;
        tmo_run("t6_edge_dist", TMO + 2);
        chk("t6_edge_data", 32'(rsp_data), 32'hC3);
`endif

        repeat (3) @(posedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Hard stop if the run wanders off.
    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
